seq_dual_shifter: RTL

- Multi-cycle, parametrised dual-channel shift/rotate unit for the ALU datapath.
- Shifts operand A and operand B by the same amount, one bit per clock.
- Supports logical left, logical right, arithmetic right and rotate right, selected per operation.
- Uses a start/busy/done handshake and reports the last bit shifted out of each channel.

---
 rtl/shifter_pkg.sv | 22 ++
 rtl/shift_step.sv | 48 ++++
 rtl/seq_dual_shifter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared types for the sequential dual-channel shifter.
//   mode_t  : 2-bit operation select (SLL, SRL, SRA, ROR)
//   state_t : controller states (IDLE, SHIFT, DONE)
// ---------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-bit step of one channel.
//   i_val  : current channel value
//   i_mode : operation select
//   o_val  : value after one 1-bit step
//   o_out  : bit that leaves the channel on this step
// ---------------------------------------------------------------------------
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  mode_t            i_mode,
  output logic [WIDTH-1:0] o_val,
  output logic             o_out
);

  // One-bit step for the selected operation.
  always_comb begin
    o_val = i_val;
    o_out = 1'b0;
    case (i_mode)
      MODE_SLL: begin
        o_val = {i_val[WIDTH-2:0], 1'b0};
        o_out = i_val[WIDTH-1];
      end
      MODE_SRL: begin
        o_val = {1'b0, i_val[WIDTH-1:1]};
        o_out = i_val[0];
      end
      MODE_SRA: begin
        o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
        o_out = i_val[0];
      end
      MODE_ROR: begin
        o_val = {i_val[0], i_val[WIDTH-1:1]};
        o_out = i_val[0];
      end
      default: begin
        o_val = i_val;
        o_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_dual_shifter.sv
// ---------------------------------------------------------------------------
// seq_dual_shifter
// Multi-cycle dual-channel shift/rotate unit, one bit per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, sampled only in IDLE
//   mode            : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   A, B, Cantidad  : operands and unsigned shift amount
//   res_a, res_b    : channel results (valid while done=1, held in IDLE)
//   cout_a, cout_b  : last bit shifted/rotated out of each channel
//   busy, done      : busy in SHIFT/DONE, done is a one-cycle pulse
// ---------------------------------------------------------------------------
module seq_dual_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CNT_W-1:0] Cantidad,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic             cout_a,
  output logic             cout_b,
  output logic             busy,
  output logic             done
);

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);

  state_t           r_state;
  mode_t            r_mode;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res_a;
  logic [WIDTH-1:0] r_res_b;
  logic             r_cout_a;
  logic             r_cout_b;
  logic             r_busy;
  logic             r_done;

  mode_t            w_mode;
  logic [31:0]      w_amt;
  logic [CW-1:0]    w_eff;
  logic [WIDTH-1:0] w_step_a;
  logic [WIDTH-1:0] w_step_b;
  logic             w_out_a;
  logic             w_out_b;

  assign w_mode = mode_t'(mode);
  assign w_amt  = 32'(Cantidad);

  // Effective step count: rotate wraps modulo WIDTH, shifts saturate at WIDTH
  // (a full-width shift already yields the final result).
  always_comb begin
    w_eff = '0;
    if (w_mode == MODE_ROR) begin
      w_eff = CW'(w_amt % 32'(WIDTH));
    end else if (w_amt >= 32'(WIDTH)) begin
      w_eff = WIDTH_C;
    end else begin
      w_eff = CW'(w_amt);
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step_a (
    .i_val  (r_res_a),
    .i_mode (r_mode),
    .o_val  (w_step_a),
    .o_out  (w_out_a)
  );

  shift_step #(.WIDTH(WIDTH)) u_step_b (
    .i_val  (r_res_b),
    .i_mode (r_mode),
    .o_val  (w_step_b),
    .o_out  (w_out_b)
  );

  // Controller, step counter and working/result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mode   <= MODE_SLL;
      r_cnt    <= '0;
      r_res_a  <= '0;
      r_res_b  <= '0;
      r_cout_a <= 1'b0;
      r_cout_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mode   <= w_mode;
            r_cnt    <= w_eff;
            r_res_a  <= A;
            r_res_b  <= B;
            r_cout_a <= 1'b0;
            r_cout_b <= 1'b0;
            r_busy   <= 1'b1;
            // Zero-length operations go straight to DONE so done appears
            // on the very next cycle.
            if (w_eff != '0) begin
              r_state <= SHIFT;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          r_res_a  <= w_step_a;
          r_res_b  <= w_step_b;
          r_cout_a <= w_out_a;
          r_cout_b <= w_out_b;
          // Counter saturates at zero; it is never 0 here in normal flow.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE_C;
          end else begin
            r_cnt <= '0;
          end
          if (r_cnt <= ONE_C) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= SHIFT;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign res_a  = r_res_a;
  assign res_b  = r_res_b;
  assign cout_a = r_cout_a;
  assign cout_b = r_cout_b;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
